// File: rtl/tx_sequencer_if.sv
// Requester/sequencer bundle for the Tx opcode sequencer.
// The requester drives job controls; the sequencer drives status and Tx.
interface tx_sequencer_if #(
    parameter int SHIFT_W = 3
);
    logic               start;
    logic [SHIFT_W-1:0] shift_count;
    logic               abort;
    logic [1:0]         Tx;
    logic               busy;
    logic               done;
    logic [4:0]         etapa;
    logic [2:0]         load_idx;

    modport master (
        output start, shift_count, abort,
        input  Tx, busy, done, etapa, load_idx
    );

    modport slave (
        input  start, shift_count, abort,
        output Tx, busy, done, etapa, load_idx
    );
endinterface

// File: rtl/tx_sequencer.sv
// Job sequencer driving the 2-bit Tx opcode bus of the register/memory
// datapath: CLEAR, a LOAD burst, N SHIFTLs, then back to HOLD.
module tx_sequencer #(
    parameter int LOAD_WORDS = 3,
    parameter int SHIFT_W    = 3
) (
    input  logic clock,
    input  logic reset_n,
    tx_sequencer_if.slave bus
);
    localparam logic [1:0] OP_RESET  = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_HOLD   = 2'b10;
    localparam logic [1:0] OP_SHIFTL = 2'b11;
    localparam logic [2:0] LAST_IDX  = 3'(LOAD_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, SHIFT, DONE, ABORT
    } state_t;

    state_t             state, nxt;
    logic [SHIFT_W-1:0] sh_lat, sh_lat_n;
    logic [SHIFT_W-1:0] rem, rem_n;
    logic [2:0]         idx_n;
    logic [4:0]         et_n;
    logic [1:0]         tx_n;
    logic               busy_n;
    logic               done_n;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            sh_lat       <= '0;
            rem          <= '0;
            bus.Tx       <= OP_HOLD;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.etapa    <= 5'd0;
            bus.load_idx <= 3'd0;
        end else begin
            state        <= nxt;
            sh_lat       <= sh_lat_n;
            rem          <= rem_n;
            bus.Tx       <= tx_n;
            bus.busy     <= busy_n;
            bus.done     <= done_n;
            bus.etapa    <= et_n;
            bus.load_idx <= idx_n;
        end
    end

    always_comb begin
        nxt      = state;
        sh_lat_n = sh_lat;
        rem_n    = rem;
        idx_n    = 3'd0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    nxt      = CLEAR;
                    sh_lat_n = bus.shift_count;
                end
            end
            DONE: begin
                if (bus.start) begin
                    nxt      = CLEAR;
                    sh_lat_n = bus.shift_count;
                end else begin
                    nxt = IDLE;
                end
            end
            CLEAR: nxt = bus.abort ? ABORT : LOAD;
            LOAD: begin
                if (bus.abort) begin
                    nxt = ABORT;
                end else if (bus.load_idx == LAST_IDX) begin
                    if (sh_lat != '0) begin
                        nxt   = SHIFT;
                        rem_n = sh_lat;
                    end else begin
                        nxt = DONE;
                    end
                end else begin
                    idx_n = bus.load_idx + 3'd1;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    nxt = ABORT;
                end else if (rem == SHIFT_W'(1)) begin
                    nxt = DONE;
                end else begin
                    rem_n = rem - SHIFT_W'(1);
                end
            end
            ABORT: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs decode the next state so they align with the state register.
    always_comb begin
        tx_n   = OP_HOLD;
        busy_n = 1'b0;
        done_n = 1'b0;
        et_n   = bus.etapa;
        unique case (nxt)
            CLEAR: begin
                tx_n   = OP_RESET;
                busy_n = 1'b1;
                et_n   = 5'd1;
            end
            LOAD: begin
                tx_n   = OP_LOAD;
                busy_n = 1'b1;
            end
            SHIFT: begin
                tx_n   = OP_SHIFTL;
                busy_n = 1'b1;
            end
            ABORT: begin
                tx_n   = OP_RESET;
                busy_n = 1'b1;
            end
            DONE:    done_n = 1'b1;
            default: tx_n   = OP_HOLD;
        endcase
        if (nxt == LOAD || nxt == SHIFT || nxt == ABORT) begin
            if (bus.etapa != 5'd31) et_n = bus.etapa + 5'd1;
        end
    end
endmodule

// File: tb/tb_tx_sequencer.sv
// Scoreboard bench for tx_sequencer: directed jobs on a default instance
// and on a LOAD_WORDS=7 instance.
module tb_tx_sequencer;
    logic clock;
    logic reset_n;

    tx_sequencer_if #(.SHIFT_W(3)) if0 ();
    tx_sequencer_if #(.SHIFT_W(3)) if1 ();

    tx_sequencer #(.LOAD_WORDS(3), .SHIFT_W(3)) u0 (
        .clock(clock), .reset_n(reset_n), .bus(if0)
    );
    tx_sequencer #(.LOAD_WORDS(7), .SHIFT_W(3)) u1 (
        .clock(clock), .reset_n(reset_n), .bus(if1)
    );

    typedef struct {
        bit         sel;
        logic [11:0] v;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [11:0] act;
            e = q.pop_front();
            if (e.sel)
                act = {if1.Tx, if1.busy, if1.done, if1.etapa, if1.load_idx};
            else
                act = {if0.Tx, if0.busy, if0.done, if0.etapa, if0.load_idx};
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got Tx=%b busy=%b done=%b etapa=%0d idx=%0d, want Tx=%b busy=%b done=%b etapa=%0d idx=%0d",
                    e.nm, act[11:10], act[9], act[8], act[7:3], act[2:0],
                    e.v[11:10], e.v[9], e.v[8], e.v[7:3], e.v[2:0]);
            end
        end
    end

    task automatic step(
        input bit sel, input bit r, input bit s, input bit a,
        input logic [2:0] sc, input logic [1:0] tx, input bit b,
        input bit d, input int et, input int idx, input string nm
    );
        exp_t e;
        @(negedge clock);
        #1;
        reset_n = r;
        if0.start = sel ? 1'b0 : s;
        if0.abort = sel ? 1'b0 : a;
        if0.shift_count = sel ? 3'd0 : sc;
        if1.start = sel ? s : 1'b0;
        if1.abort = sel ? a : 1'b0;
        if1.shift_count = sel ? sc : 3'd0;
        e.sel = sel;
        e.v = {tx, b, d, 5'(et), 3'(idx)};
        e.nm = nm;
        q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0; if0.shift_count = 3'd0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.shift_count = 3'd0;

        step(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, "reset0");
        step(0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0, "reset1");
        step(0, 1, 0, 1, 0, 2'b10, 0, 0, 0, 0, "idle0");
        step(0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, "idle1");

        // shift_count changes after start must be ignored
        step(0, 1, 1, 0, 2, 2'b00, 1, 0, 1, 0, "basic_clear");
        step(0, 1, 0, 0, 7, 2'b01, 1, 0, 2, 0, "basic_load0");
        step(0, 1, 1, 0, 7, 2'b01, 1, 0, 3, 1, "basic_load1");
        step(0, 1, 0, 0, 0, 2'b01, 1, 0, 4, 2, "basic_load2");
        step(0, 1, 0, 0, 0, 2'b11, 1, 0, 5, 0, "basic_shift0");
        step(0, 1, 0, 0, 0, 2'b11, 1, 0, 6, 0, "basic_shift1");
        step(0, 1, 0, 0, 0, 2'b10, 0, 1, 6, 0, "basic_done");
        step(0, 1, 0, 0, 0, 2'b10, 0, 0, 6, 0, "basic_idle");

        step(0, 1, 1, 0, 0, 2'b00, 1, 0, 1, 0, "zero_clear");
        step(0, 1, 0, 0, 0, 2'b01, 1, 0, 2, 0, "zero_load0");
        step(0, 1, 0, 0, 0, 2'b01, 1, 0, 3, 1, "zero_load1");
        step(0, 1, 0, 0, 0, 2'b01, 1, 0, 4, 2, "zero_load2");
        step(0, 1, 0, 0, 0, 2'b10, 0, 1, 4, 0, "zero_done");
        step(0, 1, 0, 0, 0, 2'b10, 0, 0, 4, 0, "zero_idle");

        step(0, 1, 1, 0, 5, 2'b00, 1, 0, 1, 0, "abort_clear");
        step(0, 1, 0, 0, 0, 2'b01, 1, 0, 2, 0, "abort_load0");
        step(0, 1, 0, 0, 0, 2'b01, 1, 0, 3, 1, "abort_load1");
        step(0, 1, 0, 0, 0, 2'b01, 1, 0, 4, 2, "abort_load2");
        step(0, 1, 0, 0, 0, 2'b11, 1, 0, 5, 0, "abort_shift0");
        step(0, 1, 0, 0, 0, 2'b11, 1, 0, 6, 0, "abort_shift1");
        step(0, 1, 0, 1, 0, 2'b00, 1, 0, 7, 0, "abort_state");
        step(0, 1, 0, 1, 0, 2'b10, 0, 0, 7, 0, "abort_idle");
        step(0, 1, 0, 1, 0, 2'b10, 0, 0, 7, 0, "abort_ignored");

        for (int j = 0; j < 3; j++) begin
            step(0, 1, 1, 0, 1, 2'b00, 1, 0, 1, 0, "b2b_clear");
            step(0, 1, 1, 0, 1, 2'b01, 1, 0, 2, 0, "b2b_load0");
            step(0, 1, 1, 0, 1, 2'b01, 1, 0, 3, 1, "b2b_load1");
            step(0, 1, 1, 0, 1, 2'b01, 1, 0, 4, 2, "b2b_load2");
            step(0, 1, 1, 0, 1, 2'b11, 1, 0, 5, 0, "b2b_shift");
            step(0, 1, 1, 0, 1, 2'b10, 0, 1, 5, 0, "b2b_done");
        end
        step(0, 1, 0, 0, 0, 2'b10, 0, 0, 5, 0, "b2b_idle");

        step(0, 1, 1, 0, 2, 2'b00, 1, 0, 1, 0, "rst_clear");
        step(0, 1, 0, 0, 2, 2'b01, 1, 0, 2, 0, "rst_load0");
        step(0, 1, 0, 0, 2, 2'b01, 1, 0, 3, 1, "rst_load1");
        step(0, 0, 0, 0, 2, 2'b10, 0, 0, 0, 0, "rst_midload");
        step(0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, "rst_idle");

        step(0, 1, 1, 1, 0, 2'b00, 1, 0, 1, 0, "startabort_clear");
        step(0, 1, 0, 1, 0, 2'b00, 1, 0, 2, 0, "clear_abort");
        step(0, 1, 0, 0, 0, 2'b10, 0, 0, 2, 0, "clear_abort_idle");

        step(1, 1, 1, 0, 7, 2'b00, 1, 0, 1, 0, "lw7_clear");
        for (int i = 0; i < 7; i++)
            step(1, 1, 0, 0, 0, 2'b01, 1, 0, 2 + i, i, "lw7_load");
        for (int i = 0; i < 7; i++)
            step(1, 1, 0, 0, 0, 2'b11, 1, 0, 9 + i, 0, "lw7_shift");
        step(1, 1, 0, 0, 0, 2'b10, 0, 1, 15, 0, "lw7_done");
        step(1, 1, 0, 0, 0, 2'b10, 0, 0, 15, 0, "lw7_idle");

        for (int t = 0; t < 5 && q.size() != 0; t++)
            @(negedge clock);
        @(posedge clock);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
